// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The key map is indexed [row][col] and matches the Pmod KYPD layout.
package keypad_pkg;

   localparam int COLS = 4;
   localparam int ROWS = 4;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED
   } kp_state_t;

   localparam logic [3:0] KEYMAP [0:3][0:3] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   // Index of the lowest-numbered low (pressed) row; only meaningful when rs != 4'hF.
   function automatic logic [1:0] low_row(input logic [ROWS-1:0] rs);
      logic [1:0] r;
      r = 2'd0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rs[i]) r = i[1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column dwell timer: one-cycle tick on the terminal count of a 0..SCAN_TICKS-1 counter.
// Frozen (and tick suppressed) while en is low.
module keypad_tick_gen #(
   parameter int SCAN_TICKS = 4000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [TW-1:0] LAST = TW'(SCAN_TICKS - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad scanner with press/release debounce and hex key decode.
// Define KEYPAD_SYNC_EN to pass the rows through a 2-flop synchronizer before sampling.
module keypad_scan_decoder
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 4000,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [3:0]      key_code,
   output logic            key_valid,
   output logic            key_held
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW:0] DS = (CW + 1)'(DEBOUNCE_SCANS);

   logic            tick;
   logic [ROWS-1:0] rs;

   kp_state_t       state, state_n;
   logic [1:0]      idx, idx_n;
   logic [1:0]      cap_row, cap_row_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [CW-1:0]   rel_cnt, rel_cnt_n;
   logic [3:0]      code_q, code_n;
   logic            valid_q, valid_n;
   logic            held_q, held_n;
   logic [CW:0]     cnt_inc, rel_inc;
   logic [1:0]      first_low;

   keypad_tick_gen #(
      .SCAN_TICKS (SCAN_TICKS)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .tick  (tick)
   );

`ifdef KEYPAD_SYNC_EN
   logic [ROWS-1:0] row_s0, row_s1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_s0 <= '1;
         row_s1 <= '1;
      end else begin
         row_s0 <= row;
         row_s1 <= row_s0;
      end
   end

   assign rs = row_s1;
`else
   assign rs = row;
`endif

   assign cnt_inc   = {1'b0, cnt} + (CW + 1)'(1);
   assign rel_inc   = {1'b0, rel_cnt} + (CW + 1)'(1);
   assign first_low = low_row(rs);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= SCAN;
         idx     <= 2'd0;
         cap_row <= 2'd0;
         cnt     <= '0;
         rel_cnt <= '0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         cap_row <= cap_row_n;
         cnt     <= cnt_n;
         rel_cnt <= rel_cnt_n;
         code_q  <= code_n;
         valid_q <= valid_n;
         held_q  <= held_n;
      end
   end

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      cap_row_n = cap_row;
      cnt_n     = cnt;
      rel_cnt_n = rel_cnt;
      code_n    = code_q;
      valid_n   = 1'b0;
      held_n    = held_q;
      if (tick) begin
         case (state)
            SCAN: begin
               if (rs != '1) begin
                  cap_row_n = first_low;
                  cnt_n     = CW'(1);
                  // A debounce depth of 1 accepts on the capture tick itself.
                  if (DS <= (CW + 1)'(1)) begin
                     code_n    = KEYMAP[first_low][idx];
                     valid_n   = 1'b1;
                     held_n    = 1'b1;
                     rel_cnt_n = '0;
                     state_n   = PRESSED;
                  end else begin
                     state_n = DEBOUNCE;
                  end
               end else begin
                  idx_n = idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (!rs[cap_row]) begin
                  cnt_n = cnt_inc[CW-1:0];
                  if (cnt_inc >= DS) begin
                     code_n    = KEYMAP[cap_row][idx];
                     valid_n   = 1'b1;
                     held_n    = 1'b1;
                     rel_cnt_n = '0;
                     state_n   = PRESSED;
                  end
               end else begin
                  state_n = SCAN;
                  idx_n   = idx + 2'd1;
               end
            end
            PRESSED: begin
               if (!rs[cap_row]) begin
                  rel_cnt_n = '0;
               end else if (rel_inc >= DS) begin
                  rel_cnt_n = '0;
                  held_n    = 1'b0;
                  state_n   = SCAN;
                  idx_n     = idx + 2'd1;
               end else begin
                  rel_cnt_n = rel_inc[CW-1:0];
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   assign col       = ~(COLS'(1) << idx);
   assign key_code  = code_q;
   assign key_valid = valid_q && en;
   assign key_held  = held_q;

endmodule
